// File: rtl/vga_pkg.sv
// Shared VGA-side constants: display shadow FSM encoding and default channel geometry.
package vga_pkg;

    typedef enum logic [1:0] {
        ST_BUS    = 2'd0,
        ST_TRACK  = 2'd1,
        ST_COMMIT = 2'd2
    } vga_state_e;

    localparam int VGA_W = 8;
    localparam int VGA_N = 3;

endpackage

// File: rtl/edge_rise_det.sv
// One-flop rising-edge detector; a level held high yields a single-cycle pulse.
module edge_rise_det (
    input  logic clk,
    input  logic reset_n,
    input  logic i_level,
    output logic o_rise
);

    logic r_q;

    always_ff @(posedge clk) begin
        if (!reset_n) r_q <= 1'b0;
        else          r_q <= i_level;
    end

    assign o_rise = i_level & ~r_q;

endmodule

// File: rtl/vga_display_shadow.sv
// Shadow register bank feeding the VGA character generator: immediate bus writes in
// bus mode, atomic frame-synchronised snapshot of rg_data in register mode.
module vga_display_shadow
    import vga_pkg::*;
#(
    parameter int W             = VGA_W,
    parameter int N             = VGA_N,
    parameter bit SYNC_ON_FRAME = 1'b1,
    localparam int CW           = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          sel,
    input  logic [W-1:0]  bus_data,
    input  logic          bus_wr,
    input  logic [CW-1:0] bus_ch,
    input  logic          bus_bcast,
    input  logic [N*W-1:0] rg_data,
    input  logic          frame_start,
    output logic [N*W-1:0] out_data,
    output logic          upd_pending,
    output logic          upd_done,
    output logic          mode_q
);

    vga_state_e     r_state;
    logic           r_mode_q;
    logic           r_upd_done;
    logic           r_upd_pending;
    logic           w_fs_rise;
    logic           w_bus_we;
    logic           w_commit_go;
    logic [W-1:0]   r_shadow     [N];
    logic [W-1:0]   w_shadow_nxt [N];
    logic [N*W-1:0] w_nxt_flat;

    edge_rise_det u_fs_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .i_level (frame_start),
        .o_rise  (w_fs_rise)
    );

    // Bus writes only land while both the FSM and the registered mode agree on bus mode.
    assign w_bus_we    = bus_wr && (r_state == ST_BUS) && !r_mode_q;
    assign w_commit_go = SYNC_ON_FRAME ? w_fs_rise : 1'b1;

    for (genvar k = 0; k < N; k++) begin : g_ch
        always_comb begin
            w_shadow_nxt[k] = r_shadow[k];
            if (r_state == ST_COMMIT)
                w_shadow_nxt[k] = rg_data[k*W +: W];
            else if (w_bus_we && (bus_bcast || bus_ch == CW'(k)))
                w_shadow_nxt[k] = bus_data;
        end

        always_ff @(posedge clk) begin
            if (!reset_n) r_shadow[k] <= '0;
            else          r_shadow[k] <= w_shadow_nxt[k];
        end

        assign w_nxt_flat[k*W +: W] = w_shadow_nxt[k];
        assign out_data[k*W +: W]   = r_shadow[k];
    end

    // Pending compares against the next shadow value so it drops right after a commit.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= ST_BUS;
            r_mode_q      <= 1'b0;
            r_upd_done    <= 1'b0;
            r_upd_pending <= 1'b0;
        end else begin
            r_mode_q      <= sel;
            r_upd_done    <= (r_state == ST_COMMIT);
            r_upd_pending <= r_mode_q && (rg_data != w_nxt_flat);
            case (r_state)
                ST_BUS:    if (r_mode_q) r_state <= ST_TRACK;
                ST_TRACK: begin
                    if (!r_mode_q)        r_state <= ST_BUS;
                    else if (w_commit_go) r_state <= ST_COMMIT;
                end
                ST_COMMIT: r_state <= r_mode_q ? ST_TRACK : ST_BUS;
                default:   r_state <= ST_BUS;
            endcase
        end
    end

    assign upd_pending = r_upd_pending;
    assign upd_done    = r_upd_done;
    assign mode_q      = r_mode_q;

endmodule

// File: tb/tb_vga_display_shadow.sv
// Directed bench for vga_display_shadow: frame-synced build plus a commit-every-cycle build.
module tb_vga_display_shadow;

    localparam int W = 8;
    localparam int N = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          sel, sel0;
    logic [W-1:0]  bus_data;
    logic          bus_wr;
    logic [1:0]    bus_ch;
    logic          bus_bcast;
    logic [N*W-1:0] rg_data, rg0;
    logic          frame_start;
    logic [N*W-1:0] out_data, out0;
    logic          pend, pend0, done, done0, mode, mode0;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    vga_display_shadow #(.W(W), .N(N), .SYNC_ON_FRAME(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .sel(sel), .bus_data(bus_data), .bus_wr(bus_wr),
        .bus_ch(bus_ch), .bus_bcast(bus_bcast), .rg_data(rg_data), .frame_start(frame_start),
        .out_data(out_data), .upd_pending(pend), .upd_done(done), .mode_q(mode)
    );

    vga_display_shadow #(.W(W), .N(N), .SYNC_ON_FRAME(1'b0)) dut0 (
        .clk(clk), .reset_n(reset_n), .sel(sel0), .bus_data(bus_data), .bus_wr(bus_wr),
        .bus_ch(bus_ch), .bus_bcast(bus_bcast), .rg_data(rg0), .frame_start(frame_start),
        .out_data(out0), .upd_pending(pend0), .upd_done(done0), .mode_q(mode0)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [N*W-1:0] v_exp;
        int             n_done;

        reset_n = 1'b0; sel = 1'b0; sel0 = 1'b0; bus_data = '0; bus_wr = 1'b0;
        bus_ch = '0; bus_bcast = 1'b0; rg_data = '0; rg0 = '0; frame_start = 1'b0;

        // 1: reset with random inputs
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            sel = 1'($urandom); bus_wr = 1'($urandom); bus_bcast = 1'($urandom);
            bus_ch = 2'($urandom); bus_data = 8'($urandom); rg_data = 24'($urandom);
            frame_start = 1'($urandom); sel0 = 1'($urandom); rg0 = 24'($urandom);
        end
        tick();
        chk("rst_out", out_data, 24'h0);
        chk("rst_pend", pend, 0);
        chk("rst_done", done, 0);
        chk("rst_mode", mode, 0);
        chk("rst_out0", out0, 24'h0);
        sel = 1'b0; sel0 = 1'b0; bus_wr = 1'b0; bus_bcast = 1'b0; bus_ch = '0;
        bus_data = '0; rg_data = '0; rg0 = '0; frame_start = 1'b0;
        reset_n = 1'b1;
        tick();

        // 2: bus writes
        bus_wr = 1'b1; bus_ch = 2'd1; bus_data = 8'h5A;
        tick();
        chk("bus_ch1", out_data, 24'h005A00);
        bus_ch = 2'd3; bus_data = 8'h77;
        tick();
        chk("bus_ch3_ignored", out_data, 24'h005A00);
        bus_bcast = 1'b1; bus_ch = 2'd0; bus_data = 8'hFF;
        tick();
        chk("bus_bcast", out_data, 24'hFFFFFF);
        bus_bcast = 1'b0; bus_ch = 2'd0; bus_data = 8'h11;
        tick();
        chk("bus_ch0", out_data, 24'hFFFF11);
        bus_wr = 1'b0;

        // 3: frame-synchronised commit
        sel = 1'b1; rg_data = 24'h123456;
        tick(); tick(); tick();
        chk("trk_out_hold", out_data, 24'hFFFF11);
        chk("trk_pend", pend, 1);
        chk("trk_mode", mode, 1);
        chk("trk_done", done, 0);
        frame_start = 1'b1;
        tick();
        chk("fs_e0_out", out_data, 24'hFFFF11);
        tick();
        chk("fs_commit_out", out_data, 24'h123456);
        chk("fs_commit_done", done, 1);
        chk("fs_commit_pend", pend, 0);
        rg_data = 24'h654321;
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done) n_done++;
        end
        chk("fs_hold_once", n_done, 0);
        chk("fs_hold_out", out_data, 24'h123456);
        chk("fs_hold_pend", pend, 1);
        frame_start = 1'b0;
        tick();
        frame_start = 1'b1;
        tick(); tick();
        chk("fs_second_commit", out_data, 24'h654321);
        chk("fs_second_done", done, 1);

        // 4: bus lockout in register mode
        bus_wr = 1'b1; bus_bcast = 1'b1; bus_data = 8'hAA;
        tick();
        bus_wr = 1'b0; bus_bcast = 1'b0;
        chk("lockout", out_data, 24'h654321);

        // 5: frame rise in the cycle mode_q falls
        frame_start = 1'b0; rg_data = 24'hABCDEF;
        tick();
        sel = 1'b0;
        tick();
        frame_start = 1'b1;
        tick();
        chk("race_out", out_data, 24'h654321);
        chk("race_done", done, 0);
        chk("race_mode", mode, 0);
        chk("race_pend", pend, 0);
        tick();
        chk("race_done2", done, 0);
        chk("race_out2", out_data, 24'h654321);
        frame_start = 1'b0;
        bus_wr = 1'b1; bus_ch = 2'd2; bus_data = 8'h99;
        tick();
        bus_wr = 1'b0;
        chk("race_bus_wr", out_data, 24'h994321);

        // 6: commit-every-cycle build; commits land on even edges from edge 4
        for (int e = 1; e <= 10; e++) begin
            if (e == 1) sel0 = 1'b1;
            rg0 = 24'(e * 24'h010101);
            tick();
            if (e >= 4) begin
                v_exp = 24'((e - (e % 2)) * 24'h010101);
                chk($sformatf("nosync_out_e%0d", e), out0, v_exp);
                chk($sformatf("nosync_done_e%0d", e), done0, (e % 2 == 0) ? 1 : 0);
            end
        end

        // reset during COMMIT aborts it
        sel = 1'b1; rg_data = 24'h0F0F0F;
        tick(); tick();
        frame_start = 1'b1;
        tick();
        reset_n = 1'b0;
        tick();
        chk("rst_commit_out", out_data, 24'h0);
        chk("rst_commit_done", done, 0);
        chk("rst_commit_mode", mode, 0);
        reset_n = 1'b1; sel = 1'b0; frame_start = 1'b0;
        tick();
        chk("rst_commit_done2", done, 0);
        chk("rst_commit_out2", out_data, 24'h0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
